// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared pipeline constants, bus widths and stall-bit indices
package ex_mem_reg_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int CNT_W      = 2;
    localparam int STALL_W    = 6;
    localparam int STALL_EX   = 3;
    localparam int STALL_MEM  = 4;
    localparam logic [DATA_W-1:0]     ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [ALUOP_W-1:0]    EXE_NOP_OP    = '0;
    localparam logic                  WRITE_DISABLE = 1'b0;
endpackage

// File: rtl/ex_mem_reg_pipe_dff.sv
// pipe_dff: pipeline field register with async active-low reset, synchronous clear and load
module pipe_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (clr) q <= '0;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall hold/bubble and MADD/MSUB feedback
// Optional EX_MEM_FLUSH_EN adds a synchronous flush input that clears every output.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W     = ex_mem_reg_pkg::DATA_W,
    parameter int REG_ADDR_W = ex_mem_reg_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = ex_mem_reg_pkg::ALUOP_W,
    parameter int CNT_W      = ex_mem_reg_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
`ifdef EX_MEM_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);
    localparam int WB_W  = REG_ADDR_W + 1 + DATA_W;
    localparam int HL_W  = 2 * DATA_W + 1;
    localparam int MA_W  = ALUOP_W + 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + CNT_W;
    logic adv, bub, fl, mem_clr, acc_clr, acc_ld;
    logic unused_stall;
`ifdef EX_MEM_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    assign adv          = ~stall[STALL_EX];
    assign bub          = stall[STALL_EX] & ~stall[STALL_MEM];
    assign mem_clr      = bub | fl;
    // The accumulator intermediate only survives while EX is held.
    assign acc_ld       = stall[STALL_EX];
    assign acc_clr      = adv | fl;
    assign unused_stall = ^{stall[5], stall[2:0]};
    // Clearing to zero yields the NOP bundle since all NOP/disable encodings are zero.
    pipe_dff #(.WIDTH(WB_W)) u_wb (
        .clk(clk), .rst(rst), .ld(adv), .clr(mem_clr),
        .d({ex_wd, ex_wreg, ex_wdata}),
        .q({mem_wd, mem_wreg, mem_wdata})
    );
    pipe_dff #(.WIDTH(HL_W)) u_hl (
        .clk(clk), .rst(rst), .ld(adv), .clr(mem_clr),
        .d({ex_hi, ex_lo, ex_whilo}),
        .q({mem_hi, mem_lo, mem_whilo})
    );
    pipe_dff #(.WIDTH(MA_W)) u_ma (
        .clk(clk), .rst(rst), .ld(adv), .clr(mem_clr),
        .d({ex_aluop, ex_mem_addr, ex_reg2}),
        .q({mem_aluop, mem_mem_addr, mem_reg2})
    );
    pipe_dff #(.WIDTH(ACC_W)) u_acc (
        .clk(clk), .rst(rst), .ld(acc_ld), .clr(acc_clr),
        .d({hilo_i, cnt_i}),
        .q({hilo_o, cnt_o})
    );
    a_stall_prefix: assert property (@(posedge clk) disable iff (!rst)
        !(stall[STALL_MEM] && !stall[STALL_EX]));
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven directed checks of the EX->MEM pipeline register
module tb_ex_mem_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic [7:0]  e_aluop;
        logic [31:0] e_addr;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;
    vec_t vecs[12];

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall),
`ifdef EX_MEM_FLUSH_EN
        .flush(flush),
`endif
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // hi/lo/reg2 are distinct rotations of wdata so a zero bundle stays all zero
    function automatic logic [31:0] rhi(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction
    function automatic logic [31:0] rlo(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction
    function automatic logic [31:0] rr2(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] s, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [7:0] aluop,
                         input logic [31:0] addr, input logic [63:0] hl, input logic [1:0] c);
        stall = s; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_aluop = aluop;
        ex_mem_addr = addr; ex_hi = rhi(wdata); ex_lo = rlo(wdata); ex_whilo = wreg;
        ex_reg2 = rr2(wdata); hilo_i = hl; cnt_i = c;
    endtask

    task automatic check_all(input string tag, input logic [4:0] wd, input logic wreg,
                             input logic [31:0] wdata, input logic [7:0] aluop,
                             input logic [31:0] addr, input logic [63:0] hl, input logic [1:0] c);
        chk({tag, ".mem_wd"}, 64'(mem_wd), 64'(wd));
        chk({tag, ".mem_wreg"}, 64'(mem_wreg), 64'(wreg));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        chk({tag, ".mem_hi"}, 64'(mem_hi), 64'(rhi(wdata)));
        chk({tag, ".mem_lo"}, 64'(mem_lo), 64'(rlo(wdata)));
        chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(wreg));
        chk({tag, ".mem_aluop"}, 64'(mem_aluop), 64'(aluop));
        chk({tag, ".mem_mem_addr"}, 64'(mem_mem_addr), 64'(addr));
        chk({tag, ".mem_reg2"}, 64'(mem_reg2), 64'(rr2(wdata)));
        chk({tag, ".hilo_o"}, hilo_o, hl);
        chk({tag, ".cnt_o"}, 64'(cnt_o), 64'(c));
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 5'd5, 1'b1, 32'hDEADBEEF, 8'h20, 32'h10, 64'h55, 2'd2,
                     5'd5, 1'b1, 32'hDEADBEEF, 8'h20, 32'h10, 64'h0, 2'd0};
        vecs[1]  = '{6'b001111, 5'd7, 1'b1, 32'h11111111, 8'h23, 32'h20, 64'h1_0000_0002, 2'd1,
                     5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h1_0000_0002, 2'd1};
        vecs[2]  = '{6'b000000, 5'd9, 1'b1, 32'h22222222, 8'h2B, 32'h30, 64'h77, 2'd3,
                     5'd9, 1'b1, 32'h22222222, 8'h2B, 32'h30, 64'h0, 2'd0};
        vecs[3]  = '{6'b000000, 5'd3, 1'b1, 32'hAAAA5555, 8'h24, 32'h80, 64'h66, 2'd2,
                     5'd3, 1'b1, 32'hAAAA5555, 8'h24, 32'h80, 64'h0, 2'd0};
        vecs[4]  = '{6'b011111, 5'd1, 1'b0, 32'h12345678, 8'h00, 32'h90, 64'hABC, 2'd1,
                     5'd3, 1'b1, 32'hAAAA5555, 8'h24, 32'h80, 64'hABC, 2'd1};
        vecs[5]  = '{6'b011111, 5'd2, 1'b1, 32'h87654321, 8'h2C, 32'hA0, 64'hDEF0_0000_0001, 2'd2,
                     5'd3, 1'b1, 32'hAAAA5555, 8'h24, 32'h80, 64'hDEF0_0000_0001, 2'd2};
        vecs[6]  = '{6'b111111, 5'd6, 1'b1, 32'h0F0F0F0F, 8'h21, 32'hB0, 64'h3, 2'd3,
                     5'd3, 1'b1, 32'hAAAA5555, 8'h24, 32'h80, 64'h3, 2'd3};
        vecs[7]  = '{6'b000000, 5'd31, 1'b0, 32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFC, 64'hFF, 2'd1,
                     5'd31, 1'b0, 32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFC, 64'h0, 2'd0};
        vecs[8]  = '{6'b001111, 5'd8, 1'b1, 32'h13572468, 8'h2A, 32'hC4, 64'h5, 2'd2,
                     5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h5, 2'd2};
        vecs[9]  = '{6'b001111, 5'd8, 1'b1, 32'h13572468, 8'h2A, 32'hC4, 64'h8000_0000_0000_0000, 2'd3,
                     5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h8000_0000_0000_0000, 2'd3};
        vecs[10] = '{6'b000111, 5'd2, 1'b1, 32'h0BADF00D, 8'h28, 32'h44, 64'h9, 2'd1,
                     5'd2, 1'b1, 32'h0BADF00D, 8'h28, 32'h44, 64'h0, 2'd0};
        vecs[11] = '{6'b000000, 5'd12, 1'b1, 32'h00C0FFEE, 8'h2B, 32'h48, 64'h1, 2'd1,
                     5'd12, 1'b1, 32'h00C0FFEE, 8'h2B, 32'h48, 64'h0, 2'd0};

        // reset with nonzero inputs: outputs zero at once and across edges
        drive(6'b000000, 5'd17, 1'b1, 32'hCAFEF00D, 8'h23, 32'h1234, 64'h9999, 2'd3);
        #2;
        check_all("rst_now", 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold", 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h0, 2'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].stall, vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].aluop,
                  vecs[i].addr, vecs[i].hilo, vecs[i].cnt);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_wdata,
                      vecs[i].e_aluop, vecs[i].e_addr, vecs[i].e_hilo, vecs[i].e_cnt);
        end

        // async reset between edges while holding
        drive(6'b011111, 5'd4, 1'b1, 32'h24681357, 8'h21, 32'h60, 64'h42, 2'd2);
        @(posedge clk);
        #1;
        check_all("pre_arst", 5'd12, 1'b1, 32'h00C0FFEE, 8'h2B, 32'h48, 64'h42, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        check_all("arst_now", 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h0, 2'd0);
        @(posedge clk);
        #1;
        check_all("arst_edge", 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h0, 2'd0);
        rst = 1'b1;

        // hold with flush asserted (cleared only when the flush option is built in)
        drive(6'b000000, 5'd4, 1'b1, 32'h13579BDF, 8'h20, 32'hC0, 64'h7, 2'd1);
        @(posedge clk);
        #1;
        check_all("fl_load", 5'd4, 1'b1, 32'h13579BDF, 8'h20, 32'hC0, 64'h0, 2'd0);
        drive(6'b011111, 5'd9, 1'b0, 32'h11223344, 8'h2C, 32'hD0, 64'h33, 2'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
`ifdef EX_MEM_FLUSH_EN
        check_all("flush", 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 64'h0, 2'd0);
`else
        check_all("noflush", 5'd4, 1'b1, 32'h13579BDF, 8'h20, 32'hC0, 64'h33, 2'd1);
`endif
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
